// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG conditioning chain: the von Neumann pair
// FSM states and the default sizing constants used by the packer.
package trng_pkg;

  typedef enum logic {
    PAIR_EMPTY = 1'b0,
    PAIR_HALF  = 1'b1
  } pair_state_t;

  localparam int DEFAULT_WORD_W     = 8;
  localparam int DEFAULT_RCT_CUTOFF = 32;
  localparam int DEFAULT_RCT_W      = 6;
  localparam int DEFAULT_DROP_W     = 16;

endpackage

// File: rtl/trng_rct.sv
// Repetition count health test: counts consecutive identical raw bits and
// pulses trip on the raw bit that makes the run length reach the cutoff.
module trng_rct
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF = DEFAULT_RCT_CUTOFF,
  parameter int RCT_W      = DEFAULT_RCT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic raw_bit,
  input  logic raw_valid,
  output logic trip
);

  localparam logic [RCT_W-1:0] CUTOFF  = RCT_W'(RCT_CUTOFF);
  localparam logic [RCT_W-1:0] CNT_MAX = '1;

  logic [RCT_W-1:0] cnt;
  logic [RCT_W-1:0] next_cnt;
  logic             last_bit;

  // Run length after this bit; an empty counter always starts a fresh run and
  // a long run saturates so it never wraps back under the cutoff.
  always_comb begin
    next_cnt = cnt;
    if (cnt == '0 || raw_bit != last_bit) begin
      next_cnt = RCT_W'(1);
    end else if (cnt != CNT_MAX) begin
      next_cnt = cnt + RCT_W'(1);
    end
    trip = enable && raw_valid && (next_cnt == CUTOFF);
  end

  // Run-length tracking; disabling the block forgets the current run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      last_bit <= 1'b0;
    end else if (!enable) begin
      cnt      <= '0;
    end else if (raw_valid) begin
      cnt      <= next_cnt;
      last_bit <= raw_bit;
    end
  end

endmodule

// File: rtl/trng_vn_packer.sv
// Raw ring-oscillator bit conditioner: repetition health test, von Neumann
// debiasing, packing into words and a one-word valid/ready holding register
// that counts words lost to back-pressure.
module trng_vn_packer
  import trng_pkg::*;
#(
  parameter int WORD_W     = DEFAULT_WORD_W,
  parameter int RCT_CUTOFF = DEFAULT_RCT_CUTOFF,
  parameter int RCT_W      = DEFAULT_RCT_W,
  parameter int DROP_W     = DEFAULT_DROP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              raw_bit,
  input  logic              raw_valid,
  input  logic              clear_fail,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              health_fail,
  output logic [DROP_W-1:0] drop_count
);

  localparam int                   BIT_CNT_W = $clog2(WORD_W);
  localparam logic [BIT_CNT_W-1:0] LAST_IDX  = BIT_CNT_W'(WORD_W - 1);

  pair_state_t          pair_state;
  logic                 pair_bit;
  logic [WORD_W-1:0]    shift;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 trip;
  logic                 active;
  logic                 emit_valid;
  logic                 word_done;
  logic                 holder_free;
  logic [WORD_W-1:0]    full_word;

  trng_rct #(
    .RCT_CUTOFF(RCT_CUTOFF),
    .RCT_W     (RCT_W)
  ) u_rct (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .raw_bit  (raw_bit),
    .raw_valid(raw_valid),
    .trip     (trip)
  );

  // A differing pair emits its first bit; the last bit of a word is merged
  // straight into the completed word so it can load without an extra cycle.
  always_comb begin
    active      = enable && !health_fail;
    emit_valid  = active && raw_valid && (pair_state == PAIR_HALF) && (pair_bit != raw_bit);
    word_done   = emit_valid && (bit_cnt == LAST_IDX);
    holder_free = !word_valid || word_ready;
    full_word   = shift;
    full_word[WORD_W-1] = pair_bit;
  end

  // Pair FSM and bit packer; a health trip or disable discards partial work.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pair_state <= PAIR_EMPTY;
      pair_bit   <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
    end else if (trip || !enable) begin
      pair_state <= PAIR_EMPTY;
      shift      <= '0;
      bit_cnt    <= '0;
    end else if (active && raw_valid) begin
      unique case (pair_state)
        PAIR_EMPTY: begin
          pair_bit   <= raw_bit;
          pair_state <= PAIR_HALF;
        end
        PAIR_HALF: begin
          pair_state <= PAIR_EMPTY;
          if (emit_valid) begin
            if (word_done) begin
              shift   <= '0;
              bit_cnt <= '0;
            end else begin
              shift[bit_cnt] <= pair_bit;
              bit_cnt        <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        default: pair_state <= PAIR_EMPTY;
      endcase
    end
  end

  // Holding register and saturating drop counter; a trip throws away the held word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_data  <= '0;
      word_valid <= 1'b0;
      drop_count <= '0;
    end else if (trip) begin
      word_valid <= 1'b0;
    end else begin
      if (word_done && holder_free) begin
        word_data  <= full_word;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      if (word_done && !holder_free && drop_count != '1) begin
        drop_count <= drop_count + DROP_W'(1);
      end
    end
  end

  // Sticky health failure; a new trip outranks a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      health_fail <= 1'b0;
    end else if (trip) begin
      health_fail <= 1'b1;
    end else if (clear_fail) begin
      health_fail <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trng_vn_packer.sv
// Self-checking bench for trng_vn_packer: directed scenarios plus random
// traffic, all compared each cycle against a queue-based behavioural model.
module tb_trng_vn_packer;

  localparam int WORD_W = 8;
  localparam int CUTOFF = 32;
  localparam int RUN_MAX = 63;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              raw_bit;
  logic              raw_valid;
  logic              clear_fail;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              health_fail;
  logic [15:0]       drop_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit              m_fail;
  bit              m_valid;
  logic [WORD_W-1:0] m_data;
  int              m_drop;
  bit              m_half;
  bit              m_pend;
  bit              m_bits[$];
  int              m_run;
  bit              m_run_bit;

  trng_vn_packer dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .raw_bit    (raw_bit),
    .raw_valid  (raw_valid),
    .clear_fail (clear_fail),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .health_fail(health_fail),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_fail = 0; m_valid = 0; m_data = '0; m_drop = 0;
    m_half = 0; m_pend = 0; m_bits.delete(); m_run = 0; m_run_bit = 0;
  endtask

  // One clock edge of the reference behaviour, using pre-edge state.
  task automatic model_step(input bit en, input bit rb, input bit rv, input bit cf, input bit rdy);
    bit trip = 0;
    bit completed = 0;
    bit free;
    logic [WORD_W-1:0] word = '0;
    if (en) begin
      if (rv) begin
        if (m_run == 0 || rb != m_run_bit) m_run = 1;
        else if (m_run < RUN_MAX) m_run++;
        m_run_bit = rb;
        trip = (m_run == CUTOFF);
      end
    end else begin
      m_run = 0;
    end
    if (en && !m_fail && rv) begin
      if (!m_half) begin
        m_half = 1; m_pend = rb;
      end else begin
        m_half = 0;
        if (m_pend != rb) begin
          m_bits.push_back(m_pend);
          if (m_bits.size() == WORD_W) begin
            for (int i = 0; i < WORD_W; i++) word[i] = m_bits[i];
            m_bits.delete();
            completed = 1;
          end
        end
      end
    end
    if (!en) begin
      m_half = 0; m_bits.delete();
    end
    free = !m_valid || rdy;
    if (m_valid && rdy) m_valid = 0;
    if (completed) begin
      if (free) begin m_valid = 1; m_data = word; end
      else if (m_drop != 16'hFFFF) m_drop++;
    end
    if (trip) begin
      m_fail = 1; m_valid = 0; m_half = 0; m_bits.delete();
    end else if (cf) begin
      m_fail = 0;
    end
  endtask

  task automatic compare_all();
    checkOutput("word_valid", 32'(word_valid), 32'(m_valid));
    checkOutput("word_data", 32'(word_data), 32'(m_data));
    checkOutput("health_fail", 32'(health_fail), 32'(m_fail));
    checkOutput("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  task automatic applyStimulus(input bit en, input bit rb, input bit rv, input bit cf, input bit rdy);
    enable = en; raw_bit = rb; raw_valid = rv; clear_fail = cf; word_ready = rdy;
    @(posedge clock);
    model_step(en, rb, rv, cf, rdy);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    enable = 0; raw_bit = 0; raw_valid = 0; clear_fail = 0; word_ready = 0;
    reset = 1;
    model_reset();
    #1;
    compare_all();
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  // Each word bit becomes a raw pair: 1 -> 10, 0 -> 01.
  task automatic send_word(input logic [WORD_W-1:0] w, input bit rdy, input bit rdy_last);
    for (int i = 0; i < WORD_W; i++) begin
      applyStimulus(1, w[i], 1, 0, rdy);
      applyStimulus(1, !w[i], 1, 0, (i == WORD_W - 1) ? rdy_last : rdy);
    end
  endtask

  initial begin
    do_reset();
    checkOutput("reset_valid", 32'(word_valid), 32'd0);
    checkOutput("reset_data", 32'(word_data), 32'd0);

    // Pairs 10,01,10,10,01,01,10,01 emit 1,0,1,1,0,0,1,0 with bit0 first.
    send_word(8'h4D, 1, 1);
    checkOutput("vn_word_valid", 32'(word_valid), 32'd1);
    checkOutput("vn_word_data", 32'(word_data), 32'h4D);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("vn_word_taken", 32'(word_valid), 32'd0);

    // Equal pairs contribute nothing.
    for (int i = 0; i < WORD_W; i++) begin
      applyStimulus(1, 0, 1, 0, 1); applyStimulus(1, 0, 1, 0, 1);
      applyStimulus(1, 1, 1, 0, 1); applyStimulus(1, 1, 1, 0, 1);
      applyStimulus(1, 1, 1, 0, 1); applyStimulus(1, 0, 1, 0, 1);
    end
    checkOutput("equal_pairs_data", 32'(word_data), 32'hFF);
    checkOutput("equal_pairs_valid", 32'(word_valid), 32'd1);

    // Back-pressure: first word held, later two dropped, then delivered.
    do_reset();
    send_word(8'h12, 0, 0);
    send_word(8'h34, 0, 0);
    send_word(8'h56, 0, 0);
    checkOutput("bp_held_data", 32'(word_data), 32'h12);
    checkOutput("bp_drops", 32'(drop_count), 32'd2);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("bp_delivered", 32'(word_valid), 32'd0);

    // Health trip discards the held word; clear_fail resumes operation.
    do_reset();
    send_word(8'hA5, 0, 0);
    for (int i = 0; i < CUTOFF - 1; i++) applyStimulus(1, 1, 1, 0, 0);
    checkOutput("rct_not_yet", 32'(health_fail), 32'd0);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("rct_trip", 32'(health_fail), 32'd1);
    checkOutput("rct_discard", 32'(word_valid), 32'd0);
    send_word(8'h0F, 1, 1);
    checkOutput("rct_no_words", 32'(word_valid), 32'd0);
    applyStimulus(1, 0, 1, 1, 1);
    checkOutput("rct_cleared", 32'(health_fail), 32'd0);
    send_word(8'h96, 1, 1);
    checkOutput("rct_resume", 32'(word_data), 32'h96);

    // Completing a word while the held one is accepted: no drop, no bubble.
    do_reset();
    send_word(8'h11, 0, 0);
    send_word(8'h22, 0, 1);
    checkOutput("swap_data", 32'(word_data), 32'h22);
    checkOutput("swap_valid", 32'(word_valid), 32'd1);
    checkOutput("swap_drops", 32'(drop_count), 32'd0);

    // Enable low mid-word flushes the partial word.
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, i[0], 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    send_word(8'h5A, 1, 1);
    checkOutput("flush_data", 32'(word_data), 32'h5A);

    // Asynchronous reset between clocks mid-word.
    send_word(8'h77, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, i[1], 1, 0, 0);
    #2;
    reset = 1;
    model_reset();
    #1;
    checkOutput("async_valid", 32'(word_valid), 32'd0);
    checkOutput("async_data", 32'(word_data), 32'd0);
    checkOutput("async_fail", 32'(health_fail), 32'd0);
    checkOutput("async_drop", 32'(drop_count), 32'd0);
    @(posedge clock);
    #1;
    reset = 0;
    send_word(8'hC3, 1, 1);
    checkOutput("post_reset_data", 32'(word_data), 32'hC3);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                    $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
